// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter that serialises captured words into a
// byte stream for a UART transmitter, optionally prefixed by a header byte.
module uart_tx_arbiter #(
  parameter int WIDTH  = 256,
  parameter int HDR_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_DV,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_DV,
  input  logic             uart_done,
  output logic [7:0]       uart_byte,
  output logic             uart_DV,
  output logic [1:0]       busy,
  output logic [1:0]       done,
  output logic [1:0]       overflow
);

  localparam int NBYTES = WIDTH / 8 + ((HDR_EN != 0) ? 1 : 0);
  localparam int CW     = $clog2(NBYTES + 1);
  // Bytes still to go after the first one has been presented.
  localparam logic [CW-1:0] CNT_LOAD = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e                  state_q, state_d;
  logic [1:0][WIDTH-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]        shift_q, shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic [1:0]              busy_q, busy_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              overflow_q, overflow_d;
  logic [7:0]              uart_byte_q, uart_byte_d;
  logic                    uart_dv_q, uart_dv_d;

  logic [1:0]              release_v;
  logic                    winner;
  logic [1:0]              req_dv;
  logic [1:0][WIDTH-1:0]   req_data;

  assign req_dv   = {req1_DV, req0_DV};
  assign req_data = {req1_data, req0_data};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    uart_byte_d = uart_byte_q;
    uart_dv_d   = 1'b0;
    done_d      = 2'b00;
    release_v   = 2'b00;
    winner      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (busy_q != 2'b00) begin
          // On a tie the requester that was not served last wins.
          winner = (busy_q == 2'b11) ? ~last_q : busy_q[1];
          gnt_d  = winner;
          if (HDR_EN != 0) begin
            uart_byte_d = {7'b1010000, winner};
            shift_d     = hold_q[winner];
          end else begin
            uart_byte_d = hold_q[winner][WIDTH-1 -: 8];
            shift_d     = hold_q[winner] << 8;
          end
          cnt_d     = CNT_LOAD;
          uart_dv_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (uart_done) begin
          if (cnt_q != '0) begin
            uart_byte_d = shift_q[WIDTH-1 -: 8];
            shift_d     = shift_q << 8;
            cnt_d       = cnt_q - CW'(1);
            uart_dv_d   = 1'b1;
            state_d     = SEND;
          end else begin
            done_d[gnt_q]    = 1'b1;
            release_v[gnt_q] = 1'b1;
            last_d           = gnt_q;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A requester released on this edge may capture a fresh word on the same edge.
    busy_d     = busy_q & ~release_v;
    hold_d     = hold_q;
    overflow_d = overflow_q;
    for (int i = 0; i < 2; i++) begin
      if (req_dv[i]) begin
        if (busy_d[i]) begin
          overflow_d[i] = 1'b1;
        end else begin
          hold_d[i] = req_data[i];
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      // NOTE: holding and shift registers are cleared too, so reset leaves no stale word.
      hold_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      busy_q      <= 2'b00;
      done_q      <= 2'b00;
      overflow_q  <= 2'b00;
      uart_byte_q <= 8'h00;
      uart_dv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      uart_byte_q <= uart_byte_d;
      uart_dv_q   <= uart_dv_d;
    end
  end

  assign uart_byte = uart_byte_q;
  assign uart_DV   = uart_dv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule
